// File: rtl/i2c_master_write.sv
// Single-transaction I2C master write: START, address+W, ACK, one data byte, ACK, STOP.
// SCL is built from a quarter-period tick; every bus and status output is registered.
module i2c_master_write #(
    parameter int QTR_DIV = 25
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] data,
    input  logic       sda_in,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl_out,
    output logic       sda_out,
    output logic [2:0] state_dbg
);

    // Handshake: start is a request taken only while idle (busy=0, done=0); busy then
    // covers the whole frame, done pulses once with ack_err valid, ack_err holds until the next start.
    localparam int CW = $clog2(QTR_DIV);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_ACK1, S_DATA, S_ACK2, S_STOP, S_DONE
    } state_t;

    state_t        state, state_n;
    logic [1:0]    phase, phase_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    data_q, data_n;
    logic          ack_err_n, busy_n, done_n, scl_n, sda_n;
    logic          tick;

    assign state_dbg = state;

    always_comb begin
        state_n   = state;
        phase_n   = phase;
        bit_n     = bit_cnt;
        cnt_n     = cnt;
        shreg_n   = shreg;
        data_n    = data_q;
        ack_err_n = ack_err;
        tick      = (cnt == CW'(QTR_DIV - 1));

        case (state)
            S_IDLE: begin
                cnt_n   = '0;
                phase_n = 2'd0;
                bit_n   = 3'd0;
                if (start) begin
                    state_n   = S_START;
                    shreg_n   = {addr, 1'b0};
                    data_n    = data;
                    ack_err_n = 1'b0;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                if (tick) begin
                    cnt_n   = '0;
                    phase_n = phase + 2'd1;
                    // The slave's answer is taken while SCL is high, at the end of phase 2.
                    if (phase == 2'd2 && (state == S_ACK1 || state == S_ACK2) && sda_in)
                        ack_err_n = 1'b1;
                    if (phase == 2'd3) begin
                        case (state)
                            S_START: state_n = S_ADDR;
                            S_ADDR, S_DATA: begin
                                if (bit_cnt == 3'd7) begin
                                    bit_n   = 3'd0;
                                    state_n = (state == S_ADDR) ? S_ACK1 : S_ACK2;
                                end else begin
                                    bit_n   = bit_cnt + 3'd1;
                                    shreg_n = {shreg[6:0], 1'b0};
                                end
                            end
                            S_ACK1: begin
                                if (ack_err) begin
                                    state_n = S_STOP;
                                end else begin
                                    state_n = S_DATA;
                                    shreg_n = data_q;
                                end
                            end
                            S_ACK2:  state_n = S_STOP;
                            S_STOP:  state_n = S_DONE;
                            default: state_n = state;
                        endcase
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
        endcase

        // Line levels are decoded from the next state so they change on the same edge.
        scl_n = 1'b1;
        sda_n = 1'b1;
        case (state_n)
            S_START: sda_n = ~phase_n[1];
            S_ADDR, S_DATA: begin
                scl_n = phase_n[1];
                sda_n = shreg_n[7];
            end
            S_ACK1, S_ACK2: scl_n = phase_n[1];
            S_STOP: begin
                scl_n = phase_n[1];
                sda_n = (phase_n == 2'd3);
            end
            default: ;
        endcase
        busy_n = !(state_n == S_IDLE || state_n == S_DONE);
        done_n = (state_n == S_DONE);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            phase   <= 2'd0;
            bit_cnt <= 3'd0;
            cnt     <= '0;
            shreg   <= 8'd0;
            data_q  <= 8'd0;
            ack_err <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            scl_out <= 1'b1;
            sda_out <= 1'b1;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            bit_cnt <= bit_n;
            cnt     <= cnt_n;
            shreg   <= shreg_n;
            data_q  <= data_n;
            ack_err <= ack_err_n;
            busy    <= busy_n;
            done    <= done_n;
            scl_out <= scl_n;
            sda_out <= sda_n;
        end
    end

endmodule

// File: tb/tb_i2c_master_write.sv
// Bench for i2c_master_write: random frames against a frame-level model, with a
// scoreboard monitor checking bit values on SCL rises, START/STOP shape and done timing.
module tb_i2c_master_write;

    localparam int Q = 4;
    localparam int W = 1;

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] addr = 7'd0;
    logic [7:0] data = 8'd0;
    logic       sda_in = 1'b1;
    logic       busy, done, ack_err, scl_out, sda_out;
    logic [2:0] state_dbg;

    always #5 clk_in = ~clk_in;

    i2c_master_write #(.QTR_DIV(Q)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .start(start), .addr(addr), .data(data),
        .sda_in(sda_in), .busy(busy), .done(done), .ack_err(ack_err),
        .scl_out(scl_out), .sda_out(sda_out), .state_dbg(state_dbg)
    );

    typedef struct {
        int   e0;
        int   done_cyc;
        logic err;
        int   nbits;
    } txn_t;

    txn_t         txn_q[$];
    logic [W-1:0] exp_q[$];
    int n_checks = 0, n_errors = 0, cyc = 0, frames_done = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%b required=%b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame model: bit sequence seen at SCL rises, length in slots, final ACK status.
    function automatic void push_frame(input logic [6:0] a, input logic [7:0] d,
                                       input logic n1, input logic n2, input int e0);
        logic [7:0] ab;
        int slots;
        txn_t t;
        ab = {a, 1'b0};
        for (int i = 7; i >= 0; i--) exp_q.push_back(ab[i]);
        exp_q.push_back(1'b1);
        if (!n1) begin
            for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
            exp_q.push_back(1'b1);
        end
        exp_q.push_back(1'b0);
        slots      = n1 ? 11 : 20;
        t.e0       = e0;
        t.done_cyc = e0 + slots * 4 * Q + 1;
        t.err      = n1 | n2;
        t.nbits    = n1 ? 10 : 19;
        txn_q.push_back(t);
    endfunction

    // Slave: answers in the slot after 8 and 17 received bits, junk on sda_in elsewhere.
    logic slv_nack1 = 1'b0, slv_nack2 = 1'b0;
    int   sl_bits = 0;
    logic sl_prev_scl = 1'b1, sl_win = 1'b0, sl_val = 1'b1;

    always @(negedge clk_in) begin
        if (!rst_n || busy !== 1'b1) begin
            sl_bits = 0;
            sl_win  = 1'b0;
        end else begin
            if (scl_out && !sl_prev_scl) sl_bits++;
            if (!scl_out && sl_prev_scl) begin
                sl_win = (sl_bits == 8 || sl_bits == 17);
                sl_val = (sl_bits == 8) ? slv_nack1 : slv_nack2;
            end
        end
        sl_prev_scl = (scl_out === 1'b0) ? 1'b0 : 1'b1;
        sda_in = sl_win ? sl_val : 1'($urandom_range(0, 1));
    end

    // Monitor / scoreboard
    logic m_prev_scl = 1'b1, m_prev_sda = 1'b1, m_prev_busy = 1'b0, m_prev_done = 1'b0;
    logic held_err = 1'b0;
    int   m_bits = 0, m_fall = 0, m_rise = 0, m_fall_cyc = -1, m_rise_cyc = -1;

    always @(negedge clk_in) begin
        txn_t t;
        logic [W-1:0] b;
        if (!rst_n) begin
            m_prev_scl  = 1'b1;
            m_prev_sda  = 1'b1;
            m_prev_busy = 1'b0;
            m_prev_done = 1'b0;
            held_err    = 1'b0;
        end else begin
            if (busy && !m_prev_busy) begin
                m_bits = 0; m_fall = 0; m_rise = 0; m_fall_cyc = -1; m_rise_cyc = -1;
                if (txn_q.size() == 0) begin
                    chk1("unexpected_busy", busy, 1'b0);
                end else begin
                    chkn("busy_rise_cyc", cyc, txn_q[0].e0 + 1);
                    chk1("ack_err_clear", ack_err, 1'b0);
                end
            end
            if (busy) begin
                if (scl_out && !m_prev_scl) begin
                    m_bits++;
                    if (exp_q.size() == 0) begin
                        chkn("extra_bit", m_bits, 0);
                    end else begin
                        b = exp_q.pop_front();
                        chk1($sformatf("bit%0d", m_bits), sda_out, b[0]);
                    end
                end
                if (scl_out && m_prev_scl && sda_out != m_prev_sda) begin
                    if (!sda_out) begin m_fall++; m_fall_cyc = cyc; end
                    else begin m_rise++; m_rise_cyc = cyc; end
                end
            end
            if (done && m_prev_done) begin
                chk1("done_width", done, 1'b0);
            end else if (done) begin
                if (txn_q.size() == 0) begin
                    chk1("spurious_done", done, 1'b0);
                end else begin
                    t = txn_q.pop_front();
                    chkn("done_cyc", cyc, t.done_cyc);
                    chk1("ack_err", ack_err, t.err);
                    chk1("busy_at_done", busy, 1'b0);
                    chkn("nbits", m_bits, t.nbits);
                    chkn("start_cond_cnt", m_fall, 1);
                    chkn("stop_cond_cnt", m_rise, 1);
                    chkn("start_fall_cyc", m_fall_cyc, t.e0 + 2 * Q + 1);
                    chkn("stop_rise_cyc", m_rise_cyc, t.done_cyc - Q);
                    held_err = t.err;
                end
                frames_done++;
            end else if (!busy) begin
                chk1("ack_err_hold", ack_err, held_err);
                chk1("idle_scl", scl_out, 1'b1);
                chk1("idle_sda", sda_out, 1'b1);
            end
            m_prev_scl  = scl_out;
            m_prev_sda  = sda_out;
            m_prev_busy = busy;
            m_prev_done = done;
        end
    end

    // Driver
    task automatic step();
        @(negedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [6:0] a, input logic [7:0] d, input logic n1, input logic n2);
        addr = a; data = d; slv_nack1 = n1; slv_nack2 = n2; start = 1'b1;
        push_frame(a, d, n1, n2, cyc);
        step();
        start = 1'b0;
        addr  = 7'($urandom);
        data  = 8'($urandom);
        chk1("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_done();
        int f0;
        f0 = frames_done;
        for (int i = 0; i < 400; i++) begin
            step();
            if (frames_done != f0) return;
        end
        chkn("done_timeout", frames_done, f0 + 1);
        txn_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int f0;
        int found;

        // Reset with start held high
        rst_n = 1'b0; start = 1'b1; addr = 7'h50; data = 8'hA5;
        repeat (3) begin
            step();
            chk1("rst_scl", scl_out, 1'b1);
            chk1("rst_sda", sda_out, 1'b1);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_done", done, 1'b0);
            chk1("rst_ack_err", ack_err, 1'b0);
        end
        start = 1'b0; rst_n = 1'b1;
        repeat (4) begin
            step();
            chk1("post_rst_busy", busy, 1'b0);
        end

        // Normal write with an ignored mid-frame start
        issue(7'h50, 8'hA5, 1'b0, 1'b0);
        repeat (100) step();
        addr = 7'h11; data = 8'($urandom); start = 1'b1;
        step();
        start = 1'b0;
        wait_done();

        // Start during DONE is ignored; the following idle cycle starts the next frame
        addr = 7'h11; data = 8'hFF; start = 1'b1;
        step();
        issue(7'($urandom), 8'h00, 1'b0, 1'b0);
        wait_done();

        // Address NACK, then data NACK
        step();
        issue(7'h3C, 8'($urandom), 1'b1, 1'b1);
        wait_done();
        step();
        issue(7'($urandom), 8'($urandom), 1'b0, 1'b1);
        wait_done();

        // Random frames
        for (int k = 0; k < 10; k++) begin
            repeat ($urandom_range(1, 4)) step();
            issue(7'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            wait_done();
        end

        // Reset during DATA bit 3
        step();
        issue(7'($urandom), 8'($urandom), 1'b0, 1'b0);
        found = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (sl_bits >= 13) begin
                found = 1;
                break;
            end
        end
        chkn("reach_data_bit3", found, 1);
        rst_n = 1'b0;
        txn_q.delete();
        exp_q.delete();
        f0 = frames_done;
        step();
        chk1("midrst_scl", scl_out, 1'b1);
        chk1("midrst_sda", sda_out, 1'b1);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_done", done, 1'b0);
        rst_n = 1'b1;
        repeat (350) step();
        chkn("no_done_after_reset", frames_done, f0);

        // Recovery frame
        issue(7'($urandom), 8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
        wait_done();
        repeat (3) step();
        chkn("exp_q_empty", exp_q.size(), 0);
        chkn("txn_q_empty", txn_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
